// File: rtl/aes128_core.sv
// Iterative AES-128 encrypt/decrypt core: one round per clock, round keys derived on the fly.
// Optional K10 cache for faster decryption is enabled by defining AES128_KEYCACHE_EN.
module aes128_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_key_i,
  input  logic         start_enc_i,
  input  logic         start_dec_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o,
  output logic         ready_o,
  output logic         done_o
);

  typedef enum logic [1:0] {IDLE, ENC, DEC_KEYEXP, DEC} fsm_t;

  fsm_t         fsm_q;
  logic [127:0] key_q;
  logic [127:0] rk_q;
  logic [127:0] st_q;
  logic [3:0]   rnd_q;
  logic [127:0] data_q;
  logic         done_q;
  logic         ready_q;
`ifdef AES128_KEYCACHE_EN
  logic [127:0] k10_q;
  logic         k10_vld_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(b, b);
    x3   = gf_mul(x2, b);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Recover the previous round key from the current one and the Rcon that produced it.
  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  logic [127:0] rk_fwd;
  logic [127:0] rk_bwd;
  logic [127:0] enc_pre_mc;
  logic [127:0] dec_pre_imc;

  // rnd_q holds the index of the key being produced (forward) or currently held (backward).
  assign rk_fwd      = key_fwd(rk_q, rcon(rnd_q));
  assign rk_bwd      = key_bwd(rk_q, rcon(rnd_q));
  assign enc_pre_mc  = shift_rows(sub_bytes(st_q));
  assign dec_pre_imc = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_bwd;

  // Control FSM and round datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      key_q     <= 128'd0;
      rk_q      <= 128'd0;
      st_q      <= 128'd0;
      rnd_q     <= 4'd0;
      data_q    <= 128'd0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef AES128_KEYCACHE_EN
      k10_q     <= 128'd0;
      k10_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (load_key_i) begin
            key_q <= data_i;
`ifdef AES128_KEYCACHE_EN
            k10_vld_q <= 1'b0;
`endif
          end else if (start_enc_i) begin
            st_q    <= data_i ^ key_q;
            rk_q    <= key_q;
            rnd_q   <= 4'd1;
            ready_q <= 1'b0;
            fsm_q   <= ENC;
          end else if (start_dec_i) begin
            st_q    <= data_i;
            ready_q <= 1'b0;
            fsm_q   <= DEC_KEYEXP;
`ifdef AES128_KEYCACHE_EN
            if (k10_vld_q) begin
              rk_q  <= k10_q;
              rnd_q <= 4'd11;
            end else begin
              rk_q  <= key_q;
              rnd_q <= 4'd1;
            end
`else
            rk_q  <= key_q;
            rnd_q <= 4'd1;
`endif
          end else begin
            fsm_q <= IDLE;
          end
        end
        ENC: begin
          rk_q  <= rk_fwd;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd10) begin
            data_q  <= enc_pre_mc ^ rk_fwd;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            rnd_q   <= 4'd0;
            fsm_q   <= IDLE;
`ifdef AES128_KEYCACHE_EN
            k10_q     <= rk_fwd;
            k10_vld_q <= 1'b1;
`endif
          end else begin
            st_q <= mix_columns(enc_pre_mc) ^ rk_fwd;
          end
        end
        DEC_KEYEXP: begin
          if (rnd_q == 4'd11) begin
            st_q  <= st_q ^ rk_q;
            rnd_q <= 4'd10;
            fsm_q <= DEC;
          end else begin
            rk_q  <= rk_fwd;
            rnd_q <= rnd_q + 4'd1;
`ifdef AES128_KEYCACHE_EN
            if (rnd_q == 4'd10) begin
              k10_q     <= rk_fwd;
              k10_vld_q <= 1'b1;
            end
`endif
          end
        end
        DEC: begin
          rk_q  <= rk_bwd;
          rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) begin
            data_q  <= dec_pre_imc;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            fsm_q   <= IDLE;
          end else begin
            st_q <= inv_mix_columns(dec_pre_imc);
          end
        end
        default: begin
          fsm_q   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign data_o  = data_q;
  assign done_o  = done_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_aes128_core.sv
// Directed FIPS-197 vector bench for aes128_core: latency, command filtering, priority and reset abort.
module tb_aes128_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_key_i;
  logic         start_enc_i;
  logic         start_dec_i;
  logic [127:0] data_i;
  logic [127:0] data_o;
  logic         ready_o;
  logic         done_o;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES128_KEYCACHE_EN
  localparam int DEC_LAT = 11;
`else
  localparam int DEC_LAT = 21;
`endif

  aes128_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_key_i (load_key_i),
    .start_enc_i(start_enc_i),
    .start_dec_i(start_dec_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ready_o    (ready_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic load_key(input logic [127:0] k);
    data_i     = k;
    load_key_i = 1'b1;
    @(negedge clk);
    load_key_i = 1'b0;
  endtask

  // mode 0 = encrypt, 1 = decrypt, 2 = both starts together; noise drives all commands mid-run.
  task automatic run(input string tag, input int mode, input bit noise,
                     input logic [127:0] din, input logic [127:0] exp_v, input int exp_lat);
    int lat;
    bit busy_ok;
    data_i      = din;
    start_enc_i = (mode != 1);
    start_dec_i = (mode != 0);
    @(negedge clk);
    start_enc_i = 1'b0;
    start_dec_i = 1'b0;
    data_i      = ~din;
    lat         = 0;
    busy_ok     = 1'b1;
    while (!done_o && lat < 40) begin
      if (ready_o) busy_ok = 1'b0;
      if (noise && lat == 3) begin
        load_key_i = 1'b1; start_enc_i = 1'b1; start_dec_i = 1'b1;
      end
      if (noise && lat == 5) begin
        load_key_i = 1'b0; start_enc_i = 1'b0; start_dec_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_data"}, data_o, exp_v);
    check({tag, "_ready_done"}, 128'(ready_o), 128'd1);
    check({tag, "_busy_low"}, 128'(busy_ok), 128'd1);
    @(negedge clk);
    check({tag, "_done_width"}, 128'(done_o), 128'd0);
    check({tag, "_data_hold"}, data_o, exp_v);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; load_key_i = 1'b0; start_enc_i = 1'b0; start_dec_i = 1'b0; data_i = 128'd0;
    repeat (2) @(negedge clk);
    check("rst_data", data_o, 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_ready", 128'(ready_o), 128'd1);
    rst_n = 1'b1;
    @(negedge clk);

    load_key(KEY1);
    run("enc1", 0, 1'b0, PT1, CT1, 10);
    run("dec1", 1, 1'b0, CT1, PT1, DEC_LAT);

    load_key(KEY2);
    check("keyload_data_hold", data_o, PT1);
    check("keyload_ready", 128'(ready_o), 128'd1);
    run("enc2", 0, 1'b0, PT2, CT2, 10);
    run("dec2", 1, 1'b0, CT2, PT2, DEC_LAT);

    run("enc_noise", 0, 1'b1, PT2, CT2, 10);
    run("enc_key_kept", 0, 1'b0, PT2, CT2, 10);
    run("enc_dec_both", 2, 1'b0, PT2, CT2, 10);

    // load_key_i wins over start_enc_i: no operation starts
    data_i = KEY1; load_key_i = 1'b1; start_enc_i = 1'b1;
    @(negedge clk);
    load_key_i = 1'b0; start_enc_i = 1'b0;
    check("load_enc_ready", 128'(ready_o), 128'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o) seen++;
      @(negedge clk);
    end
    check("load_enc_no_done", 128'(seen), 128'd0);
    check("load_enc_data_hold", data_o, CT2);
    run("enc_after_load", 0, 1'b0, PT1, CT1, 10);

    // abort an encryption at round 5
    data_i = PT2; start_enc_i = 1'b1;
    @(negedge clk);
    start_enc_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_data", data_o, 128'd0);
    check("abort_ready", 128'(ready_o), 128'd1);
    check("abort_done", 128'(done_o), 128'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 128'(seen), 128'd0);
    load_key(KEY1);
    run("enc_after_abort", 0, 1'b0, PT1, CT1, 10);
    run("dec_after_abort", 1, 1'b0, CT1, PT1, DEC_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
